// File: rtl/layer_pkg.sv
// Shared definitions for the layered framebuffer write controller.
// Contents:
//   - tool encodings presented on the 'tool' input
//   - rectangle capture FSM state enum
//   - clear sweep FSM state enum
//   - default brush edge lengths for brush_size 0..3
package layer_pkg;

   localparam logic [1:0] TOOL_PEN   = 2'b00;
   localparam logic [1:0] TOOL_ERASE = 2'b01;
   localparam logic [1:0] TOOL_RECT  = 2'b10;

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_DRAG   = 2'd1,
      R_WAIT   = 2'd2,
      R_COMMIT = 2'd3
   } rect_state_t;

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_WAIT  = 2'd1,
      C_SWEEP = 2'd2
   } clear_state_t;

   localparam int DEF_BRUSH_S0 = 4;
   localparam int DEF_BRUSH_S1 = 8;
   localparam int DEF_BRUSH_S2 = 16;
   localparam int DEF_BRUSH_S3 = 20;

endpackage

// File: rtl/layer_write_ctrl_region_hit.sv
// Combinational box membership test.
// The lower bounds are always inclusive. INCL_MAX selects whether the upper
// bounds are inclusive (rectangle corners) or exclusive (brush: start + size).
// Ports:
//   x, y        point under test
//   xmin, xmax  horizontal bounds
//   ymin, ymax  vertical bounds
//   hit         point lies inside the box
module region_hit #(
   parameter int W        = 11,
   parameter bit INCL_MAX = 1'b1
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] xmin,
   input  logic [W-1:0] xmax,
   input  logic [W-1:0] ymin,
   input  logic [W-1:0] ymax,
   output logic         hit
);

   generate
      if (INCL_MAX) begin : g_incl
         assign hit = (x >= xmin) && (x <= xmax) && (y >= ymin) && (y <= ymax);
      end else begin : g_excl
         assign hit = (x >= xmin) && (x < xmax) && (y >= ymin) && (y < ymax);
      end
   endgenerate

endmodule

// File: rtl/layer_write_ctrl.sv
// Per-layer write-enable generator for the layered drawing framebuffer.
// Turns cursor/tool input into registered write enables for NUM_LAYERS layer
// RAMs, following the VGA scan position. Supports pen, eraser, a two-point
// rectangle committed on the following frame, and a frame-aligned full clear.
// Ports:
//   clk, reset_n           pixel clock, asynchronous active-low reset
//   video_on, x, y         scan position and active-area flag
//   cursor_x, cursor_y     brush top-left / rectangle capture point
//   brush_size             selects BRUSH_S0..BRUSH_S3
//   tool                   00 pen, 01 eraser, 10 rect, 11 no writes
//   pen_down               drawing button level
//   layer_sel              target layers
//   clear_req              single-cycle full clear request
//   we, wr_erase, wr_x, wr_y  registered write command (one cycle after scan)
//   rect_state             rectangle FSM state for cursor preview
//   busy                   clear pending/sweeping or rectangle commit pending
//   clear_done             pulse coinciding with the final clear write
module layer_write_ctrl
   import layer_pkg::*;
#(
   parameter int NUM_LAYERS = 3,
   parameter int COORD_W    = 10,
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int BRUSH_S0   = DEF_BRUSH_S0,
   parameter int BRUSH_S1   = DEF_BRUSH_S1,
   parameter int BRUSH_S2   = DEF_BRUSH_S2,
   parameter int BRUSH_S3   = DEF_BRUSH_S3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  video_on,
   input  logic [COORD_W-1:0]    x,
   input  logic [COORD_W-1:0]    y,
   input  logic [COORD_W-1:0]    cursor_x,
   input  logic [COORD_W-1:0]    cursor_y,
   input  logic [1:0]            brush_size,
   input  logic [1:0]            tool,
   input  logic                  pen_down,
   input  logic [NUM_LAYERS-1:0] layer_sel,
   input  logic                  clear_req,
   output logic [NUM_LAYERS-1:0] we,
   output logic                  wr_erase,
   output logic [COORD_W-1:0]    wr_x,
   output logic [COORD_W-1:0]    wr_y,
   output logic [1:0]            rect_state,
   output logic                  busy,
   output logic                  clear_done
);

   // One extra bit so cursor + brush size never wraps; the brush clips at
   // the screen edge instead of reappearing at column/row 0.
   localparam int XW = COORD_W + 1;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

   rect_state_t  r_state, r_state_next;
   clear_state_t c_state, c_state_next;

   logic               pen_q;
   logic [COORD_W-1:0] p1_x, p1_y, p1_x_next, p1_y_next;
   logic [COORD_W-1:0] box_xmin, box_xmax, box_ymin, box_ymax;
   logic [COORD_W-1:0] box_xmin_next, box_xmax_next, box_ymin_next, box_ymax_next;

   logic [NUM_LAYERS-1:0] we_next;
   logic                  wr_erase_next;
   logic                  clear_done_next;

   logic [XW-1:0] brush_s;
   logic          brush_hit, rect_hit;
   logic          fs, lp, pen_rise, pen_fall, is_rect_tool;
   logic          sweep_act, commit_act, brush_act;

   assign fs           = video_on && (x == '0) && (y == '0);
   assign lp           = video_on && (x == X_LAST) && (y == Y_LAST);
   assign pen_rise     = pen_down && !pen_q;
   assign pen_fall     = !pen_down && pen_q;
   assign is_rect_tool = (tool == TOOL_RECT);

   always_comb begin
      brush_s = XW'(BRUSH_S0);
      case (brush_size)
         2'd0:    brush_s = XW'(BRUSH_S0);
         2'd1:    brush_s = XW'(BRUSH_S1);
         2'd2:    brush_s = XW'(BRUSH_S2);
         default: brush_s = XW'(BRUSH_S3);
      endcase
   end

   region_hit #(.W(XW), .INCL_MAX(1'b0)) u_brush_hit (
      .x    ({1'b0, x}),
      .y    ({1'b0, y}),
      .xmin ({1'b0, cursor_x}),
      .xmax ({1'b0, cursor_x} + brush_s),
      .ymin ({1'b0, cursor_y}),
      .ymax ({1'b0, cursor_y} + brush_s),
      .hit  (brush_hit)
   );

   region_hit #(.W(XW), .INCL_MAX(1'b1)) u_rect_hit (
      .x    ({1'b0, x}),
      .y    ({1'b0, y}),
      .xmin ({1'b0, box_xmin}),
      .xmax ({1'b0, box_xmax}),
      .ymin ({1'b0, box_ymin}),
      .ymax ({1'b0, box_ymax}),
      .hit  (rect_hit)
   );

   // The WAIT->active transition happens on the frame-start pixel itself, so
   // that pixel (0,0) is already part of the sweep/commit frame.
   assign sweep_act  = video_on && ((c_state == C_SWEEP) || ((c_state == C_WAIT) && fs));
   // A clear request cancels the rectangle in the same cycle.
   assign commit_act = video_on && !clear_req &&
                       ((r_state == R_COMMIT) || ((r_state == R_WAIT) && fs && is_rect_tool));
   assign brush_act  = video_on && pen_down && brush_hit &&
                       (r_state == R_IDLE) && (c_state == C_IDLE) &&
                       ((tool == TOOL_PEN) || (tool == TOOL_ERASE));

   // Next-state and write-command logic
   always_comb begin
      c_state_next    = c_state;
      r_state_next    = r_state;
      p1_x_next       = p1_x;
      p1_y_next       = p1_y;
      box_xmin_next   = box_xmin;
      box_xmax_next   = box_xmax;
      box_ymin_next   = box_ymin;
      box_ymax_next   = box_ymax;
      we_next         = '0;
      wr_erase_next   = 1'b0;
      clear_done_next = 1'b0;

      case (c_state)
         C_IDLE:  if (clear_req) c_state_next = C_WAIT;
         C_WAIT:  if (fs)        c_state_next = C_SWEEP;
         C_SWEEP: if (lp)        c_state_next = C_IDLE;
         default:                c_state_next = C_IDLE;
      endcase

      if (clear_req) begin
         r_state_next = R_IDLE;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (is_rect_tool && pen_rise) begin
                  p1_x_next    = cursor_x;
                  p1_y_next    = cursor_y;
                  r_state_next = R_DRAG;
               end
            end
            R_DRAG: begin
               if (!is_rect_tool) begin
                  r_state_next = R_IDLE;
               end else if (pen_fall) begin
                  box_xmin_next = (p1_x < cursor_x) ? p1_x : cursor_x;
                  box_xmax_next = (p1_x < cursor_x) ? cursor_x : p1_x;
                  box_ymin_next = (p1_y < cursor_y) ? p1_y : cursor_y;
                  box_ymax_next = (p1_y < cursor_y) ? cursor_y : p1_y;
                  r_state_next  = R_WAIT;
               end
            end
            R_WAIT: begin
               if (!is_rect_tool)  r_state_next = R_IDLE;
               else if (fs)        r_state_next = R_COMMIT;
            end
            default: begin
               if (lp) r_state_next = R_IDLE;
            end
         endcase
      end

      if (sweep_act) begin
         we_next         = '1;
         wr_erase_next   = 1'b1;
         clear_done_next = lp;
      end else if (commit_act) begin
         we_next       = rect_hit ? layer_sel : '0;
         wr_erase_next = 1'b0;
      end else if (brush_act) begin
         we_next       = layer_sel;
         wr_erase_next = (tool == TOOL_ERASE);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_state    <= C_IDLE;
         r_state    <= R_IDLE;
         pen_q      <= 1'b0;
         p1_x       <= '0;
         p1_y       <= '0;
         box_xmin   <= '0;
         box_xmax   <= '0;
         box_ymin   <= '0;
         box_ymax   <= '0;
         we         <= '0;
         wr_erase   <= 1'b0;
         wr_x       <= '0;
         wr_y       <= '0;
         clear_done <= 1'b0;
      end else begin
         c_state    <= c_state_next;
         r_state    <= r_state_next;
         pen_q      <= pen_down;
         p1_x       <= p1_x_next;
         p1_y       <= p1_y_next;
         box_xmin   <= box_xmin_next;
         box_xmax   <= box_xmax_next;
         box_ymin   <= box_ymin_next;
         box_ymax   <= box_ymax_next;
         we         <= we_next;
         wr_erase   <= wr_erase_next;
         wr_x       <= x;
         wr_y       <= y;
         clear_done <= clear_done_next;
      end
   end

   assign rect_state = r_state;
   assign busy       = (c_state != C_IDLE) || (r_state == R_WAIT) || (r_state == R_COMMIT);

endmodule

// File: doc/layer_write_ctrl.md
Name: layer_write_ctrl

Overview:
- Parametrised per-layer write-enable generator for the layered drawing framebuffer; sits between the cursor/tool input logic and the NUM_LAYERS layer RAMs, driven by the VGA scan counter.
- Supports three tools, each gated by pen_down: pen, eraser, and rectangle.
  - The rectangle tool uses a two-point capture FSM with a deferred, frame-aligned commit.
- Also performs a frame-synchronous full clear of all layers.
- Outputs are registered, with write coordinates aligned to the enables.

Parameters:
NUM_LAYERS, 3, number of layer RAMs / write-enable bits
COORD_W, 10, width of x/y coordinates
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
BRUSH_S0, 4, brush edge length (pixels) for brush_size 0
BRUSH_S1, 8, brush edge length for size 1
BRUSH_S2, 16, brush edge length for size 2
BRUSH_S3, 20, brush edge length for size 3

Ports:
clk  in  1  system pixel clock
reset_n  in  1  asynchronous active-low reset
video_on  in  1  scan position is in the active area
x  in  COORD_W  current scan x
y  in  COORD_W  current scan y
cursor_x  in  COORD_W  cursor top-left x
cursor_y  in  COORD_W  cursor top-left y
brush_size  in  2  brush size select
tool  in  2  00 pen, 01 eraser, 10 rect, 11 reserved (no writes)
pen_down  in  1  level: drawing button held
layer_sel  in  NUM_LAYERS  target layers (one-hot or multi-hot)
clear_req  in  1  single-cycle clear request
we  out  NUM_LAYERS  registered per-layer write enable
wr_erase  out  1  write transparent (1) or pen colour (0); aligned with we
wr_x  out  COORD_W  x aligned with we
wr_y  out  COORD_W  y aligned with we
rect_state  out  2  rectangle FSM state, for cursor preview logic
busy  out  1  clear pending/sweeping or rect commit pending/active
clear_done  out  1  one-cycle pulse after the last clear pixel

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous and active-low.
- Reset values: we=0, wr_erase=0, wr_x=0, wr_y=0, rect_state=R_IDLE, busy=0, clear_done=0. All latched points are 0 and clear is not pending.
- Latency: one cycle. we, wr_erase, wr_x and wr_y at cycle n+1 reflect the inputs at cycle n.
- video_on=0: we=0 next cycle, regardless of tool or state.
- Frame start (fs): video_on && x==0 && y==0.
- Last pixel (lp): video_on && x==H_RES-1 && y==V_RES-1.
- Region test:
  - Brush hit when cursor_x <= x < cursor_x+S and cursor_y <= y < cursor_y+S.
  - Sums are computed at COORD_W+1 bits, so there is no wrap; the brush clips at screen edge.
- Write priority, highest first: clear sweep > rect commit > brush.
- Clear FSM:
  - C_IDLE: clear_req goes to C_WAIT.
  - C_WAIT: fs goes to C_SWEEP.
  - C_SWEEP: we = all ones whenever video_on, with wr_erase=1. At lp, go to C_IDLE; clear_done pulses with the final write.
  - clear_req while in C_WAIT or C_SWEEP is ignored.
  - clear_req in any state forces the rect FSM to R_IDLE.
- Rect FSM:
  - R_IDLE: when tool==10 and pen_down rises, latch pt1=cursor and go to R_DRAG.
  - R_DRAG: no writes. When pen_down falls, latch pt2=cursor, store the normalised box (xmin/xmax/ymin/ymax via compare) and go to R_WAIT.
  - R_WAIT: on fs, go to R_COMMIT.
  - R_COMMIT: we = layer_sel for xmin<=x<=xmax and ymin<=y<=ymax (inclusive), with wr_erase=0. At lp, go to R_IDLE.
  - A tool change away from 10 in R_DRAG or R_WAIT aborts to R_IDLE with no writes. R_COMMIT always completes its frame unless a clear request arrives.
  - The rising/falling edges of pen_down are detected with a registered copy of pen_down, which resets to 0.
- Brush writes:
  - Pen: active when tool==00 && pen_down && brush hit && rect FSM in R_IDLE && clear FSM in C_IDLE. we=layer_sel, wr_erase=0.
  - Eraser: tool==01 under the same conditions, with wr_erase=1.
  - tool==11: no writes.
- Degenerate cases:
  - layer_sel=0 produces no writes, but FSMs still advance.
  - pt1==pt2 produces a 1x1 rectangle.
- busy = (clear state != C_IDLE) or (rect state in R_WAIT or R_COMMIT).
- Reset mid-operation returns immediately to the idle states; a partially written frame is not resumed.

Decomposition:
- Package layer_pkg:
  - tool encodings TOOL_PEN/TOOL_ERASE/TOOL_RECT;
  - rect state enum R_IDLE/R_DRAG/R_WAIT/R_COMMIT;
  - clear state enum C_IDLE/C_WAIT/C_SWEEP;
  - default brush size constants.
- One sub-module, region_hit: a combinational inclusive/exclusive box test on (x, y, xmin, xmax, ymin, ymax). It is instantiated twice: once for the brush and once for the rectangle.

Test Plan:
- Pen: tool=00, pen_down=1, brush_size=1, cursor=(100,50), layer_sel=010. Scan one frame. Expect we=010 exactly at x 100..107, y 50..57 (64 pixels), one cycle after the scan position, with wr_x/wr_y matching and wr_erase=0.
- Edge clip: cursor=(636,476), brush_size=3. Expect writes only at x 636..639, y 476..479 (16 pixels), with no wrap to x=0.
- Rect: tool=10. Press at (200,300), drag, release at (190,290). Expect no writes until the next fs. Then a single frame with we=layer_sel for x 190..200, y 290..300 (121 pixels), then rect_state=R_IDLE.
- Clear: pulse clear_req mid-frame. Expect busy=1 immediately and no clear writes until fs. Then 640x480 writes with we=111 and wr_erase=1. clear_done pulses on pixel (639,479).
- Clear during rect: clear_req asserted while in R_WAIT. Expect rect aborted (no rect writes) and the clear sweep on the next frame.
- Reset: drop reset_n mid-commit. Expect we=0 asynchronously, both FSMs idle, and no further writes after release.
